phase_step_converter: RTL and testbench



---
 rtl/phase_conv_pkg.sv | 21 ++
 rtl/phase_step_converter_sub_step.sv | 19 +
 rtl/phase_step_converter.sv | 151 +++++++++++++++
 tb/tb_phase_step_converter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_conv_pkg.sv
// Shared types and constants for the phase-to-carrier-step converter.
// Build option: define PHASE_CONV_ROUND_EN for round-to-nearest step selection.
package phase_conv_pkg;

  localparam int                     FIXDT_64_A_WIDTH           = 64;
  localparam logic signed [63:0]     M_2_PI_64B_A               = 64'sh00003243f6a8885a;
  localparam int                     CARRIER_SAMPLES_PER_PERIOD = 32;
  localparam int                     STEP_IDX_WIDTH             = $clog2(CARRIER_SAMPLES_PER_PERIOD);

  typedef logic signed [FIXDT_64_A_WIDTH-1:0] phase_t;
  typedef logic [STEP_IDX_WIDTH-1:0]          step_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    MOD,
    FIX,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/phase_step_converter_sub_step.sv
// One restoring shift-compare-subtract step, used both for the 2*pi
// reduction and for the final step-index division.
module serial_sub_step #(
  parameter int W = 65
) (
  input  logic [W-1:0] rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;

  assign shifted = {rem_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? W'(shifted - {1'b0, divisor}) : W'(shifted);

endmodule

// File: rtl/phase_step_converter.sv
// Serial phase wrap + step-index division feeding the carrier LUT address.
// Build option: PHASE_CONV_ROUND_EN selects round-to-nearest (wrap) instead of floor (clamp).
module phase_step_converter
  import phase_conv_pkg::*;
#(
  parameter int                     INPUT_WIDTH = FIXDT_64_A_WIDTH,
  parameter int                     NUM_STEPS   = CARRIER_SAMPLES_PER_PERIOD,
  parameter logic [INPUT_WIDTH-1:0] M_2_PI      = M_2_PI_64B_A,
  parameter logic [INPUT_WIDTH-1:0] PHASE_STEP  = M_2_PI / NUM_STEPS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [INPUT_WIDTH-1:0]  input_value,
  output logic                           out_valid,
  output logic [$clog2(NUM_STEPS)-1:0]   phase_in_step
);

  localparam int IDX_W = $clog2(NUM_STEPS);
  localparam int RW    = INPUT_WIDTH + 1;
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

  localparam logic [CNT_W-1:0] LAST_MOD = CNT_W'(INPUT_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(IDX_W);
  localparam logic [RW-1:0]    M2PI_W   = {1'b0, M_2_PI};
  localparam logic [RW-1:0]    STEP_W   = {1'b0, PHASE_STEP};

  state_t                  state_q, state_d;
  logic                    sign_q;
  logic [INPUT_WIDTH-1:0]  mag_q;
  logic [RW-1:0]           rem_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W:0]          quo_q;
  logic [IDX_W-1:0]        step_q;
  logic                    out_valid_q;

  logic [INPUT_WIDTH-1:0]  abs_in;
  logic [RW-1:0]           divisor;
  logic [RW-1:0]           sub_rem;
  logic                    sub_q;
  logic [RW-1:0]           fixed_rem;
  logic [RW-1:0]           div_src;
  logic [RW-1:0]           div_init_rem;
  logic [INPUT_WIDTH-1:0]  div_init_bits;
  logic [IDX_W-1:0]        step_d;

  assign abs_in = input_value[INPUT_WIDTH-1] ? INPUT_WIDTH'(-input_value) : input_value;

  // Input bits (MOD) and low remainder bits (DIV) both shift out of mag_q's MSB.
  assign divisor = (state_q == DIV) ? STEP_W : M2PI_W;

  serial_sub_step #(
    .W (RW)
  ) u_sub_step (
    .rem_in  (rem_q),
    .bit_in  (mag_q[INPUT_WIDTH-1]),
    .divisor (divisor),
    .rem_out (sub_rem),
    .q_bit   (sub_q)
  );

  assign fixed_rem = (sign_q && (rem_q != '0)) ? (M2PI_W - rem_q) : rem_q;

`ifdef PHASE_CONV_ROUND_EN
  assign div_src = fixed_rem + (STEP_W >> 1);
  assign step_d  = quo_q[IDX_W] ? '0 : quo_q[IDX_W-1:0];
`else
  assign div_src = fixed_rem;
  assign step_d  = quo_q[IDX_W] ? {IDX_W{1'b1}} : quo_q[IDX_W-1:0];
`endif

  // The quotient is below 2^(IDX_W+1), so the top bits of the dividend are
  // already a valid partial remainder; only the low IDX_W+1 bits need steps.
  assign div_init_rem  = div_src >> (IDX_W + 1);
  assign div_init_bits = {div_src[IDX_W:0], {(INPUT_WIDTH - IDX_W - 1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MOD;
      MOD:     if (cnt_q == LAST_MOD) state_d = FIX;
      FIX:     state_d = DIV;
      DIV:     if (cnt_q == LAST_DIV) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      mag_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quo_q       <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= input_value[INPUT_WIDTH-1];
            mag_q  <= abs_in;
            rem_q  <= '0;
            cnt_q  <= '0;
            quo_q  <= '0;
          end
        end
        MOD: begin
          rem_q <= sub_rem;
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          rem_q <= div_init_rem;
          mag_q <= div_init_bits;
          cnt_q <= '0;
        end
        DIV: begin
          rem_q <= sub_rem;
          mag_q <= mag_q << 1;
          quo_q <= {quo_q[IDX_W-1:0], sub_q};
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          step_q      <= step_d;
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign phase_in_step = step_q;

endmodule

// File: tb/tb_phase_step_converter.sv
// Directed bench for phase_step_converter (default parameters, 32 steps).
module tb_phase_step_converter;

  localparam int LAT = 73;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [63:0] input_value;
  logic               out_valid;
  logic [4:0]         phase_in_step;

  int checks;
  int failures;

  phase_step_converter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .input_value   (input_value),
    .out_valid     (out_valid),
    .phase_in_step (phase_in_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vectors: 2pi, 0, 5.7359, -2.7359, 2pi-1, -1, 16*STEP, 16*STEP-1, -2pi, 3*2pi+16*STEP
  logic [63:0] vec_in [10] = '{
    64'h00003243f6a8885a, 64'h0000000000000000, 64'h00002de31f8a0903,
    64'hffffea1ce075f6fd, 64'h00003243f6a88859, 64'hffffffffffffffff,
    64'h00001921fb544420, 64'h00001921fb54441f, 64'hffffcdbc095777a6,
    64'h0000afeddf4ddd2e};
`ifdef PHASE_CONV_ROUND_EN
  logic [4:0] vec_exp [10] = '{5'd0, 5'd0, 5'd29, 5'd18, 5'd0, 5'd0, 5'd16, 5'd16, 5'd0, 5'd16};
`else
  logic [4:0] vec_exp [10] = '{5'd0, 5'd0, 5'd29, 5'd18, 5'd31, 5'd31, 5'd16, 5'd15, 5'd0, 5'd16};
`endif

  // Drives one transaction; lat counts edges from accept to the edge that samples out_valid.
  task automatic run_one(input logic [63:0] x, output logic [4:0] step, output int lat,
                         output logic pulse_after);
    int n;
    lat = -1;
    step = 5'bx;
    pulse_after = 1'bx;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    input_value = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k + 1;
        step = phase_in_step;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      pulse_after = out_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    input_value = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (phase_in_step !== 5'd0) begin
      failures++;
      $display("FAIL reset_step got=%0d want=0", phase_in_step);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset: in_ready=%b out_valid=%b step=%0d", in_ready, out_valid, phase_in_step);
  endtask

  task automatic test_vectors();
    logic [4:0] step;
    int         lat;
    logic       pulse_after;
    for (int i = 0; i < 10; i++) begin
      run_one(vec_in[i], step, lat, pulse_after);
      $display("vec %0d: in=%h step=%0d lat=%0d", i, vec_in[i], step, lat);
      checks++;
      if (step !== vec_exp[i]) begin
        failures++;
        $display("FAIL vec%0d_step in=%h got=%0d want=%0d", i, vec_in[i], step, vec_exp[i]);
      end
      checks++;
      if (lat !== LAT) begin
        failures++;
        $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, LAT);
      end
      checks++;
      if (pulse_after !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_pulse_width out_valid_next=%b want=0", i, pulse_after);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int   lat;
    logic ready_ok;
    logic [4:0] step;
    lat = -1;
    ready_ok = 1'b1;
    step = 5'bx;
    input_value = 64'sh00002de31f8a0903;
    in_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 200; k++) begin
      input_value = {$urandom(), $urandom()};
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k + 1;
        step = phase_in_step;
        in_valid = 1'b0;
        break;
      end
      if (in_ready !== 1'b0) ready_ok = 1'b0;
    end
    in_valid = 1'b0;
    $display("busy: step=%0d lat=%0d ready_low=%b", step, lat, ready_ok);
    checks++;
    if (step !== 5'd29) begin
      failures++;
      $display("FAIL busy_step got=%0d want=29", step);
    end
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL busy_latency got=%0d want=%0d", lat, LAT);
    end
    checks++;
    if (ready_ok !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_ready got=high_while_busy want=low");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic       seen;
    logic [4:0] step;
    int         lat;
    logic       pulse_after;
    seen = 1'b0;
    input_value = 64'sh00002de31f8a0903;
    in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || phase_in_step !== 5'd0) begin
      failures++;
      $display("FAIL abort_reset_state got=ov%b/rdy%b/step%0d want=ov0/rdy1/step0",
               out_valid, in_ready, phase_in_step);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_out_valid got=1 want=0");
    end
    run_one(64'hffffea1ce075f6fd, step, lat, pulse_after);
    $display("abort: restart step=%0d lat=%0d", step, lat);
    checks++;
    if (step !== 5'd18 || lat !== LAT) begin
      failures++;
      $display("FAIL abort_restart got=step%0d/lat%0d want=step18/lat%0d", step, lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int         lat;
    logic [4:0] step;
    lat = -1;
    step = 5'bx;
    input_value = 64'sh00001921fb544420;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        step = phase_in_step;
        break;
      end
    end
    checks++;
    if (step !== 5'd16 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got=step%0d/rdy%b want=step16/rdy1", step, in_ready);
    end
    input_value = 64'sh00002de31f8a0903;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    step = 5'bx;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k + 1;
        step = phase_in_step;
        break;
      end
    end
    $display("b2b: second step=%0d lat=%0d", step, lat);
    checks++;
    if (step !== 5'd29 || lat !== LAT) begin
      failures++;
      $display("FAIL b2b_second got=step%0d/lat%0d want=step29/lat%0d", step, lat, LAT);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    input_value = '0;
    test_reset();
    test_vectors();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
